sha_word_collector: RTL and testbench
=====================================

# sha_word_collector

Parametrised serial-to-parallel word collector with valid/ready handshakes on both sides. It sits at the SHA output stage. It accepts digest words one per cycle from the hash core and assembles them into a single wide frame. It holds the frame until the downstream comparator/transmitter accepts it. It generalises the fixed 8x32 shift register with configurable word width, depth and word order, plus short-frame termination, backpressure and a synchronous flush.

## Interface
- WORD_W, 32, width of each input word (>=1)
- NUM_WORDS, 8, words per full frame (>=2)
- MSW_FIRST, 1, 1: first-arriving word lands in the most-significant slot; 0: first word lands in slot 0 (LSBs)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous flush of partial or pending frame
- in_valid  input  1  upstream word valid
- in_ready  output  1  collector can accept a word this cycle
- in_word  input  WORD_W  incoming word
- in_last  input  1  accepted word closes the frame early
- out_valid  output  1  assembled frame available
- out_ready  input  1  downstream accepts frame
- out_data  output  WORD_W*NUM_WORDS  assembled frame
- out_count  output  CW=$clog2(NUM_WORDS+1)  words in the presented frame
- out_short  output  1  frame was closed by in_last with fewer than NUM_WORDS words

## Operation
- States: FILL and FULL. Reset and clear both enter FILL with an internal word counter of 0.
- Slot s occupies bits [(s+1)*WORD_W-1 : s*WORD_W] of out_data.
- Placement of arrival index k:
  - MSW_FIRST=1: k goes to slot NUM_WORDS-1-k.
  - MSW_FIRST=0: k goes to slot k.
- A word is accepted when in_valid && in_ready.
- in_ready:
  - FILL: 1.
  - FULL: equals out_ready. This gives the pass-through case.
- Frame start (counter=0): the accepted word is written to its slot and all other slots are zeroed in the same edge. Short frames therefore carry zeros in unfilled slots.
- A frame closes when the accepted word is arrival index NUM_WORDS-1, or when in_last=1 on the accepted word.
  - On close, go to FULL. Latch out_count = words in frame.
  - Latch out_short = 1 only if closed by in_last with count < NUM_WORDS.
  - in_last on the NUM_WORDS-th word gives out_short=0.
- FULL:
  - out_valid=1. out_data, out_count and out_short are held stable.
  - On out_valid && out_ready the frame is consumed.
  - If a word is also accepted in that cycle, it becomes arrival 0 of the next frame and the state stays FILL with counter=1.
  - If that word also has in_last, the 1-word frame closes immediately and FULL is re-entered next cycle.
- clear has priority over all other inputs.
  - It drops the partial frame or a pending out_valid.
  - It zeroes out_data, out_count and out_short, and ignores any word presented that cycle.
- in_valid while in_ready=0 has no effect. Upstream must hold its word.

## Timing
- Reset values, applied immediately when rst is asserted: out_valid=0, out_data=0, out_count=0, out_short=0, state FILL, counter 0.
  - in_ready is 1 from the first edge after reset release. It is combinational from state and out_ready.
- Latency: out_valid rises on the edge that accepts the closing word. It is visible in the cycle after the closing word is presented.
- Throughput: one word per cycle sustained with out_ready=1. There are no bubbles between frames.
- out_valid falls on the edge where out_ready=1. It stays 0 for at least one cycle unless a 1-word in_last frame was accepted on that edge.
- Reset mid-frame or mid-FULL discards everything, with no partial output.
- in_ready is never registered. out_valid, out_data, out_count and out_short are registered.

## Test plan
- Back-to-back full frame:
  - Setup: default params, out_ready=1, words 0x00000001..0x00000008 on 8 consecutive cycles.
  - Expect: out_valid high for one cycle after the 8th word, out_data = 0x00000001_00000002_..._00000008, out_count=8, out_short=0.
- Backpressure:
  - Setup: hold out_ready=0 for 5 cycles after frame close. Then raise out_ready together with in_valid, in_word=0xAAAAAAAA.
  - Expect while held: in_ready=0 and out_data stable.
  - Expect after release: frame consumed and 0xAAAAAAAA taken as arrival 0 of the next frame. The next frame's slot 7 = 0xAAAAAAAA.
- Short frame:
  - Setup: 3 words 0x11, 0x22, 0x33 with in_last on the third.
  - Expect: out_count=3, out_short=1, slots 7..5 = 0x11, 0x22, 0x33, slots 4..0 = 0.
  - Sub-case: in_last on the 8th word gives out_short=0.
- Clear mid-frame:
  - Setup: 4 words, then clear for one cycle with in_valid=1 (word ignored), then 8 fresh words.
  - Expect: output contains only the fresh words, out_count=8.
- Async reset:
  - Setup: assert rst with out_valid=1, mid-cycle.
  - Expect: all outputs 0 immediately. After release, a full frame assembles normally.
- Parameter sweep:
  - Setup: WORD_W=16, NUM_WORDS=4, MSW_FIRST=0, words 0xA, 0xB, 0xC, 0xD.
  - Expect: out_data = 0x000D_000C_000B_000A, out_count=4.

Source files
------------

// File: rtl/sha_word_collector.sv
// sha_word_collector
// Serial-to-parallel word collector for the SHA output stage. Digest words
// arrive one per cycle over a valid/ready handshake and are packed into one
// wide frame, which is held until downstream accepts it. Frames may be cut
// short with in_last; clear flushes any partial or pending frame.
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   clear                 synchronous flush (highest priority)
//   in_valid/in_ready     upstream handshake, in_word data, in_last early close
//   out_valid/out_ready   downstream handshake for the assembled frame
//   out_data              frame, slot s at bits [(s+1)*WORD_W-1 : s*WORD_W]
//   out_count             number of words in the presented frame
//   out_short             frame was closed by in_last before NUM_WORDS words
module sha_word_collector #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter bit MSW_FIRST = 1'b1,
    localparam int CW       = $clog2(NUM_WORDS + 1),
    localparam int FRAME_W  = WORD_W * NUM_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_word,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] out_data,
    output logic [CW-1:0]      out_count,
    output logic               out_short
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRAME_W-1:0]   data_q, data_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 short_q, short_d;

    logic                 accept;
    logic [CW-1:0]        base_cnt;
    logic [CW-1:0]        slot;

    // A full collector still accepts a word when the pending frame is being
    // taken in the same cycle, giving bubble-free back-to-back frames.
    assign in_ready = (state_q == FILL) || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        count_d  = count_q;
        short_d  = short_q;
        base_cnt = cnt_q;
        slot     = '0;

        if (clear) begin
            state_d = FILL;
            cnt_d   = '0;
            data_d  = '0;
            count_d = '0;
            short_d = 1'b0;
        end else begin
            // Consuming the pending frame frees the collector; a word accepted
            // in the same cycle starts a new frame at arrival index 0.
            if (state_q == FULL && out_ready) begin
                state_d  = FILL;
                cnt_d    = '0;
                base_cnt = '0;
            end

            if (accept) begin
                slot = MSW_FIRST ? (LAST_IDX - base_cnt) : base_cnt;
                // The first word of a frame wipes stale slots so short frames
                // present zeros in the positions that never got filled.
                if (base_cnt == '0) begin
                    data_d = '0;
                end
                for (int s = 0; s < NUM_WORDS; s++) begin
                    if (slot == CW'(s)) begin
                        data_d[s*WORD_W +: WORD_W] = in_word;
                    end
                end

                if (base_cnt == LAST_IDX || in_last) begin
                    state_d = FULL;
                    cnt_d   = '0;
                    count_d = base_cnt + 1'b1;
                    short_d = (base_cnt != LAST_IDX);
                end else begin
                    cnt_d   = base_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            count_q <= count_d;
            short_q <= short_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_count = count_q;
    assign out_short = short_q;

endmodule

// File: tb/tb_sha_word_collector.sv
// Testbench for sha_word_collector: directed scenarios plus a randomized run
// on the default 8x32 MSW-first configuration, checked against a queue-based
// frame model, and a directed check of a 4x16 LSW-first instance.
module tb_sha_word_collector;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int CW = 4;
    localparam int FW = W * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear, in_valid, in_last, out_ready;
    logic [W-1:0]  in_word;
    logic          in_ready, out_valid, out_short;
    logic [FW-1:0] out_data;
    logic [CW-1:0] out_count;

    logic          s_in_valid, s_in_last, s_out_ready, s_clear;
    logic [15:0]   s_in_word;
    logic          s_in_ready, s_out_valid, s_out_short;
    logic [63:0]   s_out_data;
    logic [2:0]    s_out_count;

    always #5 clk = ~clk;

    sha_word_collector dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_short(out_short)
    );

    sha_word_collector #(.WORD_W(16), .NUM_WORDS(4), .MSW_FIRST(1'b0)) dut_small (
        .clk(clk), .rst(rst), .clear(s_clear),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_word(s_in_word), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_count(s_out_count), .out_short(s_out_short)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: words of the frame under construction, plus the frame
    // that is expected to be presented downstream.
    logic [W-1:0]  m_words[$];
    bit            m_pending;
    logic [FW-1:0] m_data;
    int            m_count;
    bit            m_short;

    function automatic logic [FW-1:0] assemble();
        logic [FW-1:0] frame;
        frame = '0;
        for (int k = 0; k < m_words.size(); k++) begin
            frame = frame | (FW'(m_words[k]) << (W * (N - 1 - k)));
        end
        return frame;
    endfunction

    task automatic resetModel();
        m_words.delete();
        m_pending = 1'b0;
        m_data    = '0;
        m_count   = 0;
        m_short   = 1'b0;
    endtask

    task automatic checkVal(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("out_valid", FW'(out_valid), FW'(m_pending));
        if (m_pending) begin
            checkVal("out_data", out_data, m_data);
            checkVal("out_count", FW'(out_count), FW'(m_count));
            checkVal("out_short", FW'(out_short), FW'(m_short));
        end
    endtask

    // Drives one cycle of inputs (called at posedge+1), checks in_ready,
    // advances the model, clocks, then checks the registered outputs.
    task automatic applyStimulus(input bit v, input logic [W-1:0] w, input bit l,
                                 input bit r, input bit c);
        bit rdy;
        in_valid  = v;
        in_word   = w;
        in_last   = l;
        out_ready = r;
        clear     = c;
        #1;
        rdy = !m_pending || r;
        checkVal("in_ready", FW'(in_ready), FW'(rdy));
        if (c) begin
            resetModel();
        end else begin
            if (m_pending && r) m_pending = 1'b0;
            if (v && rdy) begin
                m_words.push_back(w);
                if (m_words.size() == N || l) begin
                    m_pending = 1'b1;
                    m_data    = assemble();
                    m_count   = m_words.size();
                    m_short   = (m_words.size() < N);
                    m_words.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [FW-1:0] held;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_word = '0;
        s_clear = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b0; s_in_word = '0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_valid", FW'(out_valid), '0);
        checkVal("reset_data", out_data, '0);
        checkVal("reset_count", FW'(out_count), '0);
        checkVal("reset_short", FW'(out_short), '0);
        rst = 1'b0;

        $display("[TB] back-to-back full frame");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
        checkVal("b2b_data", out_data,
                 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
        checkVal("b2b_count", FW'(out_count), FW'(8));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkVal("b2b_valid_drop", FW'(out_valid), '0);

        $display("[TB] backpressure");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h100 + W'(i), 1'b0, 1'b0, 1'b0);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'hBBBBBBBB, 1'b0, 1'b0, 1'b0);
            checkVal("bp_in_ready", FW'(in_ready), '0);
            checkVal("bp_stable", out_data, held);
        end
        applyStimulus(1'b1, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0);
        checkVal("bp_consumed", FW'(out_valid), '0);
        for (int i = 1; i < 8; i++) applyStimulus(1'b1, 32'h200 + W'(i), 1'b0, 1'b1, 1'b0);
        checkVal("bp_slot7", FW'(out_data[255:224]), FW'(32'hAAAAAAAA));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] short frame");
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h33, 1'b1, 1'b1, 1'b0);
        checkVal("short_data", out_data, {32'h11, 32'h22, 32'h33, 160'h0});
        checkVal("short_count", FW'(out_count), FW'(3));
        checkVal("short_flag", FW'(out_short), FW'(1));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'h40 + W'(i), (i == 8), 1'b1, 1'b0);
        checkVal("last8_short", FW'(out_short), '0);
        checkVal("last8_count", FW'(out_count), FW'(8));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] clear mid-frame");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hC0 + W'(i), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b1);
        checkVal("clear_data", out_data, '0);
        checkVal("clear_count", FW'(out_count), '0);
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'h300 + W'(i), 1'b0, 1'b1, 1'b0);
        checkVal("clear_fresh_count", FW'(out_count), FW'(8));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] async reset");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h500 + W'(i), 1'b0, 1'b0, 1'b0);
        checkVal("pre_reset_valid", FW'(out_valid), FW'(1));
        #2 rst = 1'b1;
        #1;
        checkVal("async_valid", FW'(out_valid), '0);
        checkVal("async_data", out_data, '0);
        checkVal("async_count", FW'(out_count), '0);
        checkVal("async_short", FW'(out_short), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'h600 + W'(i), 1'b0, 1'b1, 1'b0);
        checkVal("post_reset_count", FW'(out_count), FW'(8));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("[TB] parameter sweep 4x16 LSW-first");
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_in_valid = 1'b1;
            s_in_word  = 16'hA + 16'(i);
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        checkVal("sweep_valid", FW'(s_out_valid), FW'(1));
        checkVal("sweep_data", FW'(s_out_data), FW'(64'h000D_000C_000B_000A));
        checkVal("sweep_count", FW'(s_out_count), FW'(4));
        checkVal("sweep_short", FW'(s_out_short), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
